seg_roll_animator: RTL and testbench
====================================

# seg_roll_animator

Sequencer that animates a change of the displayed 7-segment character as a vertical "roll": the old glyph slides out, the new one slides in from the opposite edge. Sits directly upstream of the character-shift stage (`moveCharUp`) and drives its `char`, `amt` and `up` inputs. Segment encoding is active-low, 7 bits, all-ones = blank.

## Interface
- `STEP_DIV`, default 5_000_000: clock cycles each animation step is held. Legal values are ≥1.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `load` input 1: request to roll to `new_char`. Sampled on a rising `clk` edge.
- `new_char` input 7: target glyph, active-low.
- `dir` input 1: roll direction. 1 = old glyph exits upward; 0 = old glyph exits downward.
- `char` output 7: glyph sent to the shift stage (registered).
- `amt` output 3: shift amount sent to the shift stage, range 0..3 (registered).
- `up` output 1: shift direction sent to the shift stage (registered).
- `busy` output 1: high while the animation is in any state other than IDLE.
- `done` output 1: one-cycle pulse when an animation completes.

## Operation
- Reset values:
  - `char` = 7'h7F, `amt` = 0, `up` = 0, `busy` = 0, `done` = 0.
  - State = IDLE, divider = 0, pending buffer empty.
- Internal registers:
  - `old` holds the glyph currently settled on the display.
  - `tgt` and `dir_r` hold the target glyph and direction captured on load.
- States and their registered outputs:
  - IDLE: (`old`, 0, 0).
  - OUT1: (`old`, 1, `dir_r`).
  - OUT2: (`old`, 2, `dir_r`).
  - BLANK: (7'h7F, 3, 0).
  - IN2: (`tgt`, 2, ~`dir_r`).
  - IN1: (`tgt`, 1, ~`dir_r`).
- Transitions:
  - IDLE & `load` → OUT1. Captures `tgt` = `new_char` and `dir_r` = `dir`.
  - OUT1 → OUT2 → BLANK → IN2 → IN1 → IDLE. Each advance happens on a divider step.
  - IN1 → IDLE sets `old` = `tgt`, so the new glyph is shown at `amt` 0, and pulses `done`.
- Divider:
  - Clears on every state entry.
  - Steps when it reaches `STEP_DIV`-1.
  - Width is clog2(`STEP_DIV`), with a minimum of 1 bit.
- `load` while busy: handling depends on `SEG_ROLL_QUEUE_EN` (see Configuration).
- `new_char` equal to `old` still runs the full animation.
- `rst` asserted mid-animation aborts immediately to the reset values. The pending buffer is cleared.

## Timing
- `load` sampled at edge 0 (with S = `STEP_DIV`):
  - OUT1 is visible in cycles 1..S.
  - OUT2: S+1..2S.
  - BLANK: 2S+1..3S.
  - IN2: 3S+1..4S.
  - IN1: 4S+1..5S.
  - In cycle 5S+1: IDLE, `char` = `tgt`, `amt` = 0, `done` = 1, `busy` = 0.
- Total load-to-done latency is 5S+1 cycles.
- `busy` rises in cycle 1, together with OUT1.
- With S = 1, each state lasts exactly one cycle.

## Configuration
- Macro: `SEG_ROLL_QUEUE_EN`.
- Defined:
  - A one-entry pending buffer (glyph + direction) captures `load` while `busy`. The last write wins.
  - In the IDLE/`done` cycle, a valid pending entry is treated as a `load`. OUT1 begins the next cycle, and the entry is then cleared.
  - `load` in that same cycle overrides the pending entry.
- Undefined: `load` while `busy` is ignored and there is no buffer.

## Structure
- Package `seg_roll_pkg` contains:
  - The state enum (IDLE, OUT1, OUT2, BLANK, IN2, IN1).
  - `SEG_BLANK` = 7'h7F.
  - The `amt` width constant (3).
- Sub-module `step_divider`, parameterised by `STEP_DIV`:
  - Input `restart`.
  - Output `step` pulse.
  - Async active-high reset.
- The top-level module holds the FSM, the output registers and the pending buffer.

## Test plan
- Reset with S = 4 → `char` = 7'h7F, `amt` = 0, `up` = 0, `busy` = 0, `done` = 0, held until the first `load`.
- `load`, `new_char` = 7'h25, `dir` = 1, S = 4 → outputs (7F,1,1), (7F,2,1), (7F,3,0), (25,2,0), (25,1,0), each for 4 cycles. Then (25,0,0) with `done` = 1 at cycle 21.
- From settled 7'h25: `load` 7'h79, `dir` = 0 → (25,1,0), (25,2,0), (7F,3,0), (79,2,1), (79,1,1), then `char` = 7'h79.
- With `SEG_ROLL_QUEUE_EN` defined: loads of 7'h12 then 7'h30 during an animation → the second animation targets 7'h30 only and starts one cycle after `done`. Without the macro, both loads are ignored.
- `rst` pulse during BLANK → outputs return to reset values immediately, and a later `load` runs the full 5S+1 sequence.
- S = 1: `load` 7'h40 → one state per cycle, `done` in cycle 6.

Source files
------------

// File: rtl/seg_roll_pkg.sv
// Shared types and constants for the 7-segment roll animator.
package seg_roll_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OUT1  = 3'd1,
        OUT2  = 3'd2,
        BLANK = 3'd3,
        IN2   = 3'd4,
        IN1   = 3'd5
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         AMT_W     = 3;

endpackage

// File: rtl/step_divider.sv
// Free-running step divider: pulses `step` every STEP_DIV cycles, realigned by `restart`.
module step_divider #(
    parameter int STEP_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic step
);

    localparam int W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [W-1:0] cnt;

    assign step = (cnt == W'(STEP_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart || step)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seg_roll_animator.sv
// Roll animation sequencer driving the moveCharUp shift stage.
// Optional SEG_ROLL_QUEUE_EN adds a one-entry pending buffer for loads arriving while busy.
module seg_roll_animator
    import seg_roll_pkg::*;
#(
    parameter int STEP_DIV = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [6:0]       new_char,
    input  logic             dir,
    output logic [6:0]       char,
    output logic [AMT_W-1:0] amt,
    output logic             up,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [6:0]       old, old_n, tgt, tgt_n;
    logic             dir_r, dir_n;
    logic [6:0]       char_n;
    logic [AMT_W-1:0] amt_n;
    logic             up_n, done_n;
    logic             start, step, restart;
    logic [6:0]       ld_char;
    logic             ld_dir;

`ifdef SEG_ROLL_QUEUE_EN
    logic       pend_v, pend_v_n, pend_d, pend_d_n;
    logic [6:0] pend_c, pend_c_n;
`endif

    // Every state change realigns the divider so each state lasts STEP_DIV cycles.
    assign restart = (state_n != state);
    assign busy    = (state != IDLE);

    step_divider #(.STEP_DIV(STEP_DIV)) u_div (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .step    (step)
    );

    always_comb begin
        state_n = state;
        old_n   = old;
        tgt_n   = tgt;
        dir_n   = dir_r;
        done_n  = 1'b0;
        ld_char = new_char;
        ld_dir  = dir;
        start   = load;
`ifdef SEG_ROLL_QUEUE_EN
        pend_v_n = pend_v;
        pend_c_n = pend_c;
        pend_d_n = pend_d;
        // A live load in the idle cycle takes priority over the buffered one.
        if (!load && pend_v) begin
            ld_char = pend_c;
            ld_dir  = pend_d;
        end
        start = load || pend_v;
        if (state != IDLE && load) begin
            pend_v_n = 1'b1;
            pend_c_n = new_char;
            pend_d_n = dir;
        end
`endif
        case (state)
            IDLE: if (start) begin
                state_n = OUT1;
                tgt_n   = ld_char;
                dir_n   = ld_dir;
`ifdef SEG_ROLL_QUEUE_EN
                pend_v_n = 1'b0;
`endif
            end
            OUT1:  if (step) state_n = OUT2;
            OUT2:  if (step) state_n = BLANK;
            BLANK: if (step) state_n = IN2;
            IN2:   if (step) state_n = IN1;
            IN1: if (step) begin
                state_n = IDLE;
                old_n   = tgt;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        char_n = old_n;
        amt_n  = '0;
        up_n   = 1'b0;
        case (state_n)
            OUT1:  begin amt_n = AMT_W'(1); up_n = dir_n; end
            OUT2:  begin amt_n = AMT_W'(2); up_n = dir_n; end
            BLANK: begin char_n = SEG_BLANK; amt_n = AMT_W'(3); end
            IN2:   begin char_n = tgt_n; amt_n = AMT_W'(2); up_n = ~dir_n; end
            IN1:   begin char_n = tgt_n; amt_n = AMT_W'(1); up_n = ~dir_n; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old   <= SEG_BLANK;
            tgt   <= SEG_BLANK;
            dir_r <= 1'b0;
            char  <= SEG_BLANK;
            amt   <= '0;
            up    <= 1'b0;
            done  <= 1'b0;
        end else begin
            old   <= old_n;
            tgt   <= tgt_n;
            dir_r <= dir_n;
            char  <= char_n;
            amt   <= amt_n;
            up    <= up_n;
            done  <= done_n;
        end
    end

`ifdef SEG_ROLL_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v <= 1'b0;
            pend_c <= SEG_BLANK;
            pend_d <= 1'b0;
        end else begin
            pend_v <= pend_v_n;
            pend_c <= pend_c_n;
            pend_d <= pend_d_n;
        end
    end
`endif

endmodule

// File: tb/tb_seg_roll_animator.sv
// Bench for seg_roll_animator: per-cycle schedule model (S=4) plus literal spot checks (S=4, S=1).
module tb_seg_roll_animator;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load = 1'b0, dir = 1'b0;
    logic [6:0] new_char = 7'h00;
    logic [6:0] char_o;
    logic [2:0] amt_o;
    logic       up_o, busy_o, done_o;

    logic       loadb = 1'b0, dirb = 1'b0;
    logic [6:0] new_charb = 7'h00;
    logic [6:0] charb;
    logic [2:0] amtb;
    logic       upb, busyb, doneb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_roll_animator #(.STEP_DIV(S)) dut (
        .clk(clk), .rst(rst), .load(load), .new_char(new_char), .dir(dir),
        .char(char_o), .amt(amt_o), .up(up_o), .busy(busy_o), .done(done_o)
    );

    seg_roll_animator #(.STEP_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .load(loadb), .new_char(new_charb), .dir(dirb),
        .char(charb), .amt(amtb), .up(upb), .busy(busyb), .done(doneb)
    );

    function automatic logic [12:0] pk(logic [6:0] c, logic [2:0] a, logic u, logic b, logic d);
        return {c, a, u, b, d};
    endfunction

    task automatic chk(string nm, logic [12:0] act, logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act char=%h amt=%0d up=%b busy=%b done=%b exp char=%h amt=%0d up=%b busy=%b done=%b",
                     nm, act[12:6], act[5:3], act[2], act[1], act[0],
                     exp[12:6], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    wire [12:0] outs  = {char_o, amt_o, up_o, busy_o, done_o};
    wire [12:0] outsb = {charb, amtb, upb, busyb, doneb};

    // Model: each accepted load expands into the full per-cycle output schedule.
    logic [12:0] q[$];
    logic [6:0]  mold = 7'h7F;
    logic        pv = 1'b0, pd = 1'b0;
    logic [6:0]  pc = 7'h00;

    task automatic schedule(logic [6:0] o, logic [6:0] t, logic d);
        logic [6:0] ch[5];
        logic [2:0] am[5];
        logic       u[5];
        ch = '{o, o, 7'h7F, t, t};
        am = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1};
        u  = '{d, d, 1'b0, ~d, ~d};
        for (int p = 0; p < 5; p++)
            for (int k = 0; k < S; k++)
                q.push_back(pk(ch[p], am[p], u[p], 1'b1, 1'b0));
        q.push_back(pk(t, 3'd0, 1'b0, 1'b0, 1'b1));
    endtask

    initial forever begin
        logic [12:0] dummy;
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            pv   = 1'b0;
            mold = 7'h7F;
        end else begin
            if (q.size() > 0) dummy = q.pop_front();
            if (q.size() == 0 && (load || pv)) begin
                if (load) schedule(mold, new_char, dir);
                else      schedule(mold, pc, pd);
                mold = load ? new_char : pc;
                pv   = 1'b0;
            end else if (q.size() != 0 && load) begin
`ifdef SEG_ROLL_QUEUE_EN
                pv = 1'b1;
                pc = new_char;
                pd = dir;
`endif
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("model", outs, (q.size() > 0) ? q[0] : pk(mold, 3'd0, 1'b0, 1'b0, 1'b0));
    end

    task automatic do_load(logic [6:0] c, logic d);
        @(negedge clk);
        load = 1'b1; new_char = c; dir = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_load(logic [6:0] c, logic d);
        load = 1'b1; new_char = c; dir = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {12'h0, busy_o}, 13'h0);
    endtask

    initial begin
        logic [12:0] eb[1:6];
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", outs, pk(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0));
        chk("reset_b", outsb, pk(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0));

        // Roll 7F -> 25 upward.
        do_load(7'h25, 1'b1);
        chk("c1_out1", outs, pk(7'h7F, 3'd1, 1'b1, 1'b1, 1'b0));
        repeat (4) @(negedge clk);
        chk("c5_out2", outs, pk(7'h7F, 3'd2, 1'b1, 1'b1, 1'b0));
        repeat (4) @(negedge clk);
        chk("c9_blank", outs, pk(7'h7F, 3'd3, 1'b0, 1'b1, 1'b0));
        repeat (4) @(negedge clk);
        chk("c13_in2", outs, pk(7'h25, 3'd2, 1'b0, 1'b1, 1'b0));
        repeat (4) @(negedge clk);
        chk("c17_in1", outs, pk(7'h25, 3'd1, 1'b0, 1'b1, 1'b0));
        repeat (4) @(negedge clk);
        chk("c21_done", outs, pk(7'h25, 3'd0, 1'b0, 1'b0, 1'b1));
        repeat (3) @(negedge clk);

        // Roll 25 -> 79 downward with two loads arriving mid-animation.
        do_load(7'h79, 1'b0);
        chk("d1_out1", outs, pk(7'h25, 3'd1, 1'b0, 1'b1, 1'b0));
        repeat (2) @(negedge clk);
        pulse_load(7'h12, 1'b0);
        repeat (3) @(negedge clk);
        pulse_load(7'h30, 1'b1);
        repeat (5) @(negedge clk);
        chk("d13_in2", outs, pk(7'h79, 3'd2, 1'b1, 1'b1, 1'b0));
        repeat (8) @(negedge clk);
        chk("d21_done", outs, pk(7'h79, 3'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
`ifdef SEG_ROLL_QUEUE_EN
        chk("d22_pending", outs, pk(7'h79, 3'd1, 1'b1, 1'b1, 1'b0));
        repeat (16) @(negedge clk);
        chk("p17_in1", outs, pk(7'h30, 3'd1, 1'b0, 1'b1, 1'b0));
`else
        chk("d22_ignored", outs, pk(7'h79, 3'd0, 1'b0, 1'b0, 1'b0));
`endif
        wait_idle();
        repeat (2) @(negedge clk);

        // Reset during BLANK aborts, then a fresh full roll.
        do_load(7'h06, 1'b1);
        repeat (9) @(negedge clk);
        chk("r10_blank", outs, pk(7'h7F, 3'd3, 1'b0, 1'b1, 1'b0));
        #2 rst = 1'b1;
        #1 chk("r_abort", outs, pk(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        do_load(7'h40, 1'b0);
        chk("e1_out1", outs, pk(7'h7F, 3'd1, 1'b0, 1'b1, 1'b0));
        repeat (20) @(negedge clk);
        chk("e21_done", outs, pk(7'h40, 3'd0, 1'b0, 1'b0, 1'b1));
        repeat (2) @(negedge clk);

        // S = 1: one state per cycle, done in cycle 6.
        eb[1] = pk(7'h7F, 3'd1, 1'b0, 1'b1, 1'b0);
        eb[2] = pk(7'h7F, 3'd2, 1'b0, 1'b1, 1'b0);
        eb[3] = pk(7'h7F, 3'd3, 1'b0, 1'b1, 1'b0);
        eb[4] = pk(7'h40, 3'd2, 1'b1, 1'b1, 1'b0);
        eb[5] = pk(7'h40, 3'd1, 1'b1, 1'b1, 1'b0);
        eb[6] = pk(7'h40, 3'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        loadb = 1'b1; new_charb = 7'h40; dirb = 1'b0;
        @(negedge clk);
        loadb = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("s1_c%0d", c), outsb, eb[c]);
            @(negedge clk);
        end
        chk("s1_settled", outsb, pk(7'h40, 3'd0, 1'b0, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
